// File: rtl/cnn_layer_accel_rd_arb.sv
// cnn_layer_accel_rd_arb
//   Merges NUM_CLIENTS read-request ports onto one upstream read master.
//   Round-robin grant, up to MAX_OUTSTANDING reads in flight. A tag FIFO
//   remembers which client each issued read belongs to, so returning data,
//   ready and completion are steered to the client at the FIFO head.
// Ports
//   clk_intf, rst            : clock, async active-high reset
//   cl_rd_req/_id/_addr/_len : per-client request level + packed fields
//   cl_rd_req_ack            : per-client one-cycle acceptance pulse
//   cl_rd_data(_vld/_rdy)    : broadcast data, per-client valid/ready
//   cl_rd_cmpl               : per-client completion pulse
//   init_rd_req/_id/_addr/_len, init_rd_req_ack : registered upstream request
//   init_rd_data(_vld/_rdy), init_rd_cmpl        : upstream return path
//   rd_outstanding           : tag FIFO occupancy
module cnn_layer_accel_rd_arb #(
   parameter int NUM_CLIENTS     = 4,
   parameter int ID_WTH          = 8,
   parameter int ADDR_WTH        = 64,
   parameter int LEN_WTH         = 32,
   parameter int DATA_WTH        = 512,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                clk_intf,
   input  logic                                rst,
   input  logic [NUM_CLIENTS-1:0]              cl_rd_req,
   input  logic [NUM_CLIENTS*ID_WTH-1:0]       cl_rd_req_id,
   input  logic [NUM_CLIENTS*ADDR_WTH-1:0]     cl_rd_addr,
   input  logic [NUM_CLIENTS*LEN_WTH-1:0]      cl_rd_len,
   output logic [NUM_CLIENTS-1:0]              cl_rd_req_ack,
   output logic [DATA_WTH-1:0]                 cl_rd_data,
   output logic [NUM_CLIENTS-1:0]              cl_rd_data_vld,
   input  logic [NUM_CLIENTS-1:0]              cl_rd_data_rdy,
   output logic [NUM_CLIENTS-1:0]              cl_rd_cmpl,
   output logic                                init_rd_req,
   output logic [ID_WTH-1:0]                   init_rd_req_id,
   output logic [ADDR_WTH-1:0]                 init_rd_addr,
   output logic [LEN_WTH-1:0]                  init_rd_len,
   input  logic                                init_rd_req_ack,
   input  logic [DATA_WTH-1:0]                 init_rd_data,
   input  logic                                init_rd_data_vld,
   output logic                                init_rd_data_rdy,
   input  logic                                init_rd_cmpl,
   output logic [$clog2(MAX_OUTSTANDING):0]    rd_outstanding
);
   localparam int IDX_W = $clog2(NUM_CLIENTS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     grant_q, grant_d;
   logic                 req_q, req_d;
   logic [ID_WTH-1:0]    id_q, id_d;
   logic [ADDR_WTH-1:0]  addr_q, addr_d;
   logic [LEN_WTH-1:0]   len_q, len_d;

   logic [IDX_W-1:0]     tag_mem_q [2**PTR_W];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 push, pop, empty, full;
   logic [IDX_W-1:0]     head;

   logic                 sel_vld;
   logic [IDX_W-1:0]     sel_idx;
   int                   cand;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign head  = tag_mem_q[rd_ptr_q];
   assign pop   = init_rd_cmpl & ~empty;   // completion on empty FIFO is dropped

   // Round-robin pick: scan offsets high to low so the smallest offset from
   // rr_ptr that is requesting wins.
   always_comb begin
      sel_vld = |cl_rd_req;
      sel_idx = rr_ptr_q;
      cand    = 0;
      for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
         if (cl_rd_req[cand]) sel_idx = IDX_W'(cand);
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      req_d    = req_q;
      id_d     = id_q;
      addr_d   = addr_q;
      len_d    = len_q;
      push     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel_vld && !full) begin
               grant_d = sel_idx;
               id_d    = cl_rd_req_id[int'(sel_idx)*ID_WTH +: ID_WTH];
               addr_d  = cl_rd_addr[int'(sel_idx)*ADDR_WTH +: ADDR_WTH];
               len_d   = cl_rd_len[int'(sel_idx)*LEN_WTH +: LEN_WTH];
               req_d   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (init_rd_req_ack) begin
               req_d    = 1'b0;
               push     = 1'b1;
               rr_ptr_d = (grant_q == IDX_W'(NUM_CLIENTS-1)) ? '0 : grant_q + 1'b1;
               state_d  = S_ACK;
            end
         end
         // One-cycle ack window gives the client an edge to drop req
         // before IDLE looks at it again.
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_intf or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         req_q    <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         req_q    <= req_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage only; validity is tracked by cnt_q so no reset is needed.
   always_ff @(posedge clk_intf) begin
      if (push) tag_mem_q[wr_ptr_q] <= grant_q;
   end

   always_comb begin
      cl_rd_req_ack = '0;
      if (state_q == S_ACK) cl_rd_req_ack[grant_q] = 1'b1;
   end

   // Zero-latency return steering from the FIFO head.
   always_comb begin
      cl_rd_data_vld   = '0;
      cl_rd_cmpl       = '0;
      init_rd_data_rdy = 1'b0;
      if (!empty) begin
         cl_rd_data_vld[head] = init_rd_data_vld;
         cl_rd_cmpl[head]     = init_rd_cmpl;
         init_rd_data_rdy     = cl_rd_data_rdy[head];
      end
   end

   assign cl_rd_data     = init_rd_data;
   assign init_rd_req    = req_q;
   assign init_rd_req_id = id_q;
   assign init_rd_addr   = addr_q;
   assign init_rd_len    = len_q;
   assign rd_outstanding = cnt_q;

endmodule

// File: tb/tb_cnn_layer_accel_rd_arb.sv
// Directed bench for cnn_layer_accel_rd_arb (4 clients, 4 outstanding).
module tb_cnn_layer_accel_rd_arb;
   localparam int N = 4;

   logic          clk_intf = 1'b0;
   logic          rst;
   logic [N-1:0]  cl_rd_req;
   logic [N*8-1:0]  cl_rd_req_id;
   logic [N*64-1:0] cl_rd_addr;
   logic [N*32-1:0] cl_rd_len;
   logic [N-1:0]  cl_rd_req_ack;
   logic [511:0]  cl_rd_data;
   logic [N-1:0]  cl_rd_data_vld;
   logic [N-1:0]  cl_rd_data_rdy;
   logic [N-1:0]  cl_rd_cmpl;
   logic          init_rd_req;
   logic [7:0]    init_rd_req_id;
   logic [63:0]   init_rd_addr;
   logic [31:0]   init_rd_len;
   logic          init_rd_req_ack;
   logic [511:0]  init_rd_data;
   logic          init_rd_data_vld;
   logic          init_rd_data_rdy;
   logic          init_rd_cmpl;
   logic [2:0]    rd_outstanding;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk_intf = ~clk_intf;

   cnn_layer_accel_rd_arb dut (
      .clk_intf(clk_intf), .rst(rst),
      .cl_rd_req(cl_rd_req), .cl_rd_req_id(cl_rd_req_id),
      .cl_rd_addr(cl_rd_addr), .cl_rd_len(cl_rd_len),
      .cl_rd_req_ack(cl_rd_req_ack), .cl_rd_data(cl_rd_data),
      .cl_rd_data_vld(cl_rd_data_vld), .cl_rd_data_rdy(cl_rd_data_rdy),
      .cl_rd_cmpl(cl_rd_cmpl),
      .init_rd_req(init_rd_req), .init_rd_req_id(init_rd_req_id),
      .init_rd_addr(init_rd_addr), .init_rd_len(init_rd_len),
      .init_rd_req_ack(init_rd_req_ack), .init_rd_data(init_rd_data),
      .init_rd_data_vld(init_rd_data_vld), .init_rd_data_rdy(init_rd_data_rdy),
      .init_rd_cmpl(init_rd_cmpl), .rd_outstanding(rd_outstanding)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_intf);
      #1;
   endtask

   task automatic set_cl(input int c, input logic [7:0] id, input logic [63:0] a,
                         input logic [31:0] l);
      cl_rd_req_id[c*8 +: 8]  = id;
      cl_rd_addr[c*64 +: 64]  = a;
      cl_rd_len[c*32 +: 32]   = l;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cl_rd_req = '0; cl_rd_data_rdy = '0;
      init_rd_req_ack = 1'b0; init_rd_data_vld = 1'b0; init_rd_cmpl = 1'b0;
      init_rd_data = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // Request from client c with instant upstream ack; returns in ACK state.
   task automatic issue_one(input int c);
      logic got;
      got = 1'b0;
      cl_rd_req[c] = 1'b1;
      init_rd_req_ack = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (cl_rd_req_ack[c]) begin got = 1'b1; break; end
      end
      cl_rd_req[c] = 1'b0;
      init_rd_req_ack = 1'b0;
      chk("issue_one_ack", {63'd0, got}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int n;
      cl_rd_req_id = '0; cl_rd_addr = '0; cl_rd_len = '0;
      // ---------------- reset values (return inputs active during reset)
      rst = 1'b1;
      cl_rd_req = '0; cl_rd_data_rdy = '1;
      init_rd_req_ack = 1'b0; init_rd_data = '0;
      init_rd_data_vld = 1'b1; init_rd_cmpl = 1'b1;
      tick(); tick();
      chk("rst_req", init_rd_req, 0);
      chk("rst_id", init_rd_req_id, 0);
      chk("rst_addr", init_rd_addr, 0);
      chk("rst_len", init_rd_len, 0);
      chk("rst_ack", cl_rd_req_ack, 0);
      chk("rst_outst", rd_outstanding, 0);
      chk("rst_vld", cl_rd_data_vld, 0);
      chk("rst_rdy", init_rd_data_rdy, 0);
      chk("rst_cmpl", cl_rd_cmpl, 0);
      do_reset();

      // ---------------- single read from client 2
      set_cl(2, 8'h5A, 64'h1000, 32'd64);
      cl_rd_req = 4'b0100;
      tick();
      chk("sr_req", init_rd_req, 1);
      chk("sr_id", init_rd_req_id, 64'h5A);
      chk("sr_addr", init_rd_addr, 64'h1000);
      chk("sr_len", init_rd_len, 64);
      chk("sr_ack_early", cl_rd_req_ack, 0);
      tick();
      chk("sr_req_hold", init_rd_req, 1);
      chk("sr_addr_hold", init_rd_addr, 64'h1000);
      init_rd_req_ack = 1'b1;
      tick();
      chk("sr_ack", cl_rd_req_ack, 4'b0100);
      chk("sr_req_clr", init_rd_req, 0);
      chk("sr_outst1", rd_outstanding, 1);
      cl_rd_req = '0; init_rd_req_ack = 1'b0;
      tick();
      chk("sr_ack_1cyc", cl_rd_req_ack, 0);
      tick();
      chk("sr_no_reissue", init_rd_req, 0);
      init_rd_data = {8{64'hDEAD_BEEF_0000_0002}};
      init_rd_data_vld = 1'b1; cl_rd_data_rdy = 4'b1111;
      #1;
      chk("sr_vld", cl_rd_data_vld, 4'b0100);
      chk("sr_rdy", init_rd_data_rdy, 1);
      chk("sr_data", cl_rd_data[63:0], 64'hDEAD_BEEF_0000_0002);
      tick();
      init_rd_data_vld = 1'b0; init_rd_cmpl = 1'b1;
      #1;
      chk("sr_cmpl", cl_rd_cmpl, 4'b0100);
      tick();
      init_rd_cmpl = 1'b0;
      chk("sr_outst0", rd_outstanding, 0);

      // ---------------- round robin, all requesting, instant ack
      do_reset();
      for (int c = 0; c < N; c++) set_cl(c, 8'(8'h10 + c), 64'h2000 + 64'(c) * 64'h100, 32'(32 + c));
      cl_rd_req = 4'hF; init_rd_req_ack = 1'b1; init_rd_cmpl = 1'b1;
      k = 0;
      for (int t = 0; t < 60 && k < 5; t++) begin
         tick();
         if (init_rd_req) chk("rr_id", init_rd_req_id, 64'(8'h10 + (k % 4)));
         if (cl_rd_req_ack != 0) begin
            chk("rr_grant", cl_rd_req_ack, 64'(1 << (k % 4)));
            k++;
         end
      end
      chk("rr_count", k, 5);
      cl_rd_req = '0; init_rd_req_ack = 1'b0; init_rd_cmpl = 1'b0;

      // ---------------- full stall, then push+pop on one edge
      do_reset();
      set_cl(0, 8'h33, 64'h3000, 32'd0);
      cl_rd_req = 4'b0001; init_rd_req_ack = 1'b1;
      n = 0;
      for (int t = 0; t < 25; t++) begin
         tick();
         if (cl_rd_req_ack[0]) n++;
      end
      chk("full_acks", n, 4);
      chk("full_outst", rd_outstanding, 4);
      chk("full_stall", init_rd_req, 0);
      init_rd_cmpl = 1'b1;
      #1;
      chk("full_cmpl", cl_rd_cmpl, 4'b0001);
      tick();
      init_rd_cmpl = 1'b0;
      chk("full_outst3", rd_outstanding, 3);
      chk("full_req_wait", init_rd_req, 0);
      tick();
      chk("full_resume", init_rd_req, 1);
      chk("len0_fwd", init_rd_len, 0);
      init_rd_cmpl = 1'b1;   // pop on the same edge as the push
      tick();
      chk("pp_ack", cl_rd_req_ack, 4'b0001);
      chk("pp_outst", rd_outstanding, 3);
      init_rd_cmpl = 1'b0; cl_rd_req = '0; init_rd_req_ack = 1'b0;

      // ---------------- completion on empty FIFO
      do_reset();
      cl_rd_data_rdy = 4'hF; init_rd_cmpl = 1'b1;
      #1;
      chk("empty_cmpl", cl_rd_cmpl, 0);
      chk("empty_rdy", init_rd_data_rdy, 0);
      tick();
      init_rd_cmpl = 1'b0;
      chk("empty_outst", rd_outstanding, 0);

      // ---------------- backpressure on head client 1
      do_reset();
      set_cl(1, 8'h41, 64'h4000, 32'd128);
      issue_one(1);
      init_rd_data_vld = 1'b1; cl_rd_data_rdy = 4'hF;
      #1;
      chk("bp_rdy_on", init_rd_data_rdy, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         cl_rd_data_rdy = 4'b1101;
         #1;
         chk("bp_rdy_off", init_rd_data_rdy, 0);
         chk("bp_vld", cl_rd_data_vld, 4'b0010);
         tick();
      end
      cl_rd_data_rdy = 4'hF;
      #1;
      chk("bp_rdy_back", init_rd_data_rdy, 1);
      init_rd_data_vld = 1'b0;

      // ---------------- async reset while in ISSUE with 2 outstanding
      do_reset();
      for (int c = 0; c < N; c++) set_cl(c, 8'(8'hC0 + c), 64'h5000 + 64'(c), 32'd16);
      issue_one(1);
      issue_one(2);
      cl_rd_req = 4'b1000;
      tick(); tick();
      chk("ar_issue", init_rd_req, 1);
      chk("ar_issue_id", init_rd_req_id, 64'hC3);
      chk("ar_outst2", rd_outstanding, 2);
      init_rd_data_vld = 1'b1; cl_rd_data_rdy = 4'hF;
      #2 rst = 1'b1;
      #1;
      chk("ar_req", init_rd_req, 0);
      chk("ar_id", init_rd_req_id, 0);
      chk("ar_addr", init_rd_addr, 0);
      chk("ar_outst", rd_outstanding, 0);
      chk("ar_vld", cl_rd_data_vld, 0);
      chk("ar_ack", cl_rd_req_ack, 0);
      #2 rst = 1'b0;
      init_rd_data_vld = 1'b0;
      cl_rd_req = 4'b1010;
      tick();
      chk("ar_next_req", init_rd_req, 1);
      chk("ar_next_id", init_rd_req_id, 64'hC1);
      init_rd_req_ack = 1'b1;
      tick();
      chk("ar_next_ack", cl_rd_req_ack, 4'b0010);
      cl_rd_req = '0; init_rd_req_ack = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
